// File: rtl/memory_init_pkg.sv
// ============================================================================
//  memory_init_pkg : state encoding and ce-step costs shared by the memory
//                    initialiser and anything that reasons about its timing.
//  Revision 1.0
// ============================================================================
`default_nettype none

package memory_init_pkg;

  localparam logic [2:0] ST_START  = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_NEXT   = 3'd3;
  localparam logic [2:0] ST_VSETUP = 3'd4;
  localparam logic [2:0] ST_VCHECK = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  // ce steps spent per word in the write pass and in the optional read-back pass
  localparam int WR_STEPS = 3;
  localparam int VF_STEPS = 2;

  typedef enum logic [2:0] {
    S_START  = ST_START,
    S_SETUP  = ST_SETUP,
    S_WRITE  = ST_WRITE,
    S_NEXT   = ST_NEXT,
    S_VSETUP = ST_VSETUP,
    S_VCHECK = ST_VCHECK,
    S_DONE   = ST_DONE
  } state_e;

endpackage

`default_nettype wire

// File: rtl/memory_init_if.sv
// ============================================================================
//  memory_init_if : ROM read port, SRAM pins and control/status of the
//                   memory initialiser. master = initialiser side.
//  Revision 1.0
// ============================================================================
`default_nettype none

interface memory_init_if #(
  parameter int AW = 19,
  parameter int RW = 16,
  parameter int DW = 8
) ();
  import memory_init_pkg::*;

  logic          ce;
  logic          restart;
  logic [RW-1:0] romA;
  logic [DW-1:0] romQ;
  logic [AW-1:0] sramA;
  logic [DW-1:0] sramD;
  logic [DW-1:0] sramQ;
  logic          sramWe;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  ce, restart, romQ, sramQ,
    output romA, sramA, sramD, sramWe, busy, done, err
  );

  modport slave (
    output ce, restart, romQ, sramQ,
    input  romA, sramA, sramD, sramWe, busy, done, err
  );

endinterface

`default_nettype wire

// File: rtl/memory_init.sv
// ============================================================================
//  memory_init : copies a ROM image into SRAM and fills the remainder with
//                FILL, holding the system busy until the pass completes.
//                MEMORY_INIT_VERIFY_EN adds a read-back pass with sticky err.
//  Revision 1.0
// ============================================================================
`default_nettype none

module memory_init
  import memory_init_pkg::*;
#(
  parameter int            AW   = 19,
  parameter int            RW   = 16,
  parameter int            DW   = 8,
  parameter logic [DW-1:0] FILL = '0
) (
  input  logic          clock,
  input  logic          reset,
  memory_init_if.master bus
);

  localparam logic [AW-1:0] ADDR_LAST = '1;
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  state_e        state_q,  state_d;
  logic [AW-1:0] addr_q,   addr_d;
  logic [RW-1:0] rom_a_q,  rom_a_d;
  logic [AW-1:0] sram_a_q, sram_a_d;
  logic          we_q,     we_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;
  logic          err_q,    err_d;

  logic [AW-1:0] addr_inc;
  logic          addr_last;
  logic          in_fill;
  logic [DW-1:0] word_value;

  assign addr_inc  = addr_q + ADDR_ONE;
  assign addr_last = (addr_q == ADDR_LAST);
  // Any bit at or above RW set means the word lies beyond the ROM image.
  assign in_fill    = |(addr_q >> RW);
  // romQ comes from a ROM clocked by ce, so it is already settled in WRITE/VCHECK.
  assign word_value = in_fill ? FILL : bus.romQ;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rom_a_d  = rom_a_q;
    sram_a_d = sram_a_q;
    we_d     = we_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;

    if (bus.ce) begin
      unique case (state_q)
        S_START: begin
          state_d  = S_SETUP;
          rom_a_d  = addr_q[RW-1:0];
          sram_a_d = addr_q;
          we_d     = 1'b1;
        end
        S_SETUP: begin
          state_d = S_WRITE;
          we_d    = 1'b0;
        end
        S_WRITE: begin
          state_d = S_NEXT;
          we_d    = 1'b1;
        end
        S_NEXT: begin
          addr_d   = addr_inc;
          rom_a_d  = addr_inc[RW-1:0];
          sram_a_d = addr_inc;
          if (!addr_last) begin
            state_d = S_SETUP;
          end else begin
`ifdef MEMORY_INIT_VERIFY_EN
            state_d = S_VSETUP;
`else
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end
        end
`ifdef MEMORY_INIT_VERIFY_EN
        S_VSETUP: begin
          state_d = S_VCHECK;
        end
        S_VCHECK: begin
          if (bus.sramQ != word_value) begin
            err_d = 1'b1;
          end
          addr_d   = addr_inc;
          rom_a_d  = addr_inc[RW-1:0];
          sram_a_d = addr_inc;
          if (!addr_last) begin
            state_d = S_VSETUP;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
`endif
        S_DONE: begin
          if (bus.restart) begin
            state_d  = S_SETUP;
            addr_d   = '0;
            rom_a_d  = '0;
            sram_a_d = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            err_d    = 1'b0;
          end
        end
        default: begin
          state_d = S_START;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_START;
      addr_q   <= '0;
      rom_a_q  <= '0;
      sram_a_q <= '0;
      we_q     <= 1'b1;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rom_a_q  <= rom_a_d;
      sram_a_q <= sram_a_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.romA   = rom_a_q;
  assign bus.sramA  = sram_a_q;
  assign bus.sramD  = word_value;
  assign bus.sramWe = we_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

`ifdef MEMORY_INIT_VERIFY_EN
  assign bus.err = err_q;
`else
  logic unused_verify;
  assign unused_verify = ^{bus.sramQ, err_q};
  assign bus.err       = 1'b0;
`endif

endmodule

`default_nettype wire
